reduce_ingress_arbiter: RTL and testbench
=========================================

Name: reduce_ingress_arbiter

Overview:
Parametrised front end of the node reduction path. It replaces the fixed six per-direction reduce FIFOs, the fixed-fan-in selector and the local-injection mux with one block. Router eject flits carrying reduce opcodes are buffered per lane and arbitrated round-robin against local reduce_me injections. Local injection has bounded priority. A registered valid/ready output feeds the reduce FIFO / reduce_unit.

Parameters:
NUM_LANES, 6, number of router eject lanes
FLIT_W, 85, flit-plus-children width (FlitChildWidth at lg_numprocs=3)
VALID_POS, 81, flit valid bit index
OP_POS, 32, LSB of 4-bit op field; reduce tag = bits [OP_POS+3:OP_POS+2]
LANE_DEPTH, 16, entries per lane FIFO (power of two)
LG_DEPTH, 4, log2(LANE_DEPTH)
LOCAL_MAX_STREAK, 4, maximum consecutive local grants while any lane is pending

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
eject_flit  in  NUM_LANES*FLIT_W  lane i occupies bits [i*FLIT_W +: FLIT_W]
eject_valid  in  NUM_LANES  per-lane eject strobe
lane_full  out  NUM_LANES  lane FIFO holds LANE_DEPTH entries
overflow_sticky  out  NUM_LANES  lane dropped a flit since reset
local_flit  in  FLIT_W  local reduce_me flit
local_ready  out  1  local flit is taken this cycle
out_flit  out  FLIT_W  registered output flit
out_valid  out  1  out_flit is valid
out_ready  in  1  downstream accepts out_flit

Behaviour:
- Reset (rst=0, async): out_valid=0, out_flit=0, lane pointers and counts=0, lane_full=0, overflow_sticky=0, rr pointer=0, streak=0. local_ready is forced to 0 while rst=0.
- Capture: lane i pushes only when eject_valid[i], eject_flit_i[VALID_POS]=1 and op bits [OP_POS+3:OP_POS+2]=2'b11. All other flits are ignored.
- Lane FIFO: first-word-fall-through, occupancy counter 0..LANE_DEPTH. Pointers wrap modulo LANE_DEPTH.
- Full lane: a push is accepted only if count<LANE_DEPTH, or if the same lane is popped in the same cycle (count unchanged). Otherwise the flit is dropped, overflow_sticky[i] is set, and count is unchanged.
- Local request is local_flit[VALID_POS]. No local buffering; local_ready is combinational.
- load = !out_valid || out_ready. Arbitration happens only when load=1.
- Candidates are the local request and the non-empty lanes.
- Local wins if requested and (no lane non-empty, or streak < LOCAL_MAX_STREAK). Otherwise a lane wins.
- Lane choice: first non-empty lane searching from rr pointer upward with wrap. On a lane grant, rr pointer <= granted+1 mod NUM_LANES, and that lane pops.
- Streak: increments (saturating) on a local grant while any lane is non-empty. Clears on any lane grant, or on a local grant with all lanes empty.
- Grant effect: out_flit <= winner flit, out_valid <= 1, single-cycle latency from grant to out_valid.
- If load=1 and there is no candidate, out_valid <= 0 and out_flit holds.
- If load=0, out_flit, out_valid, rr pointer and streak hold, and there are no pops.
- A flit pushed in cycle t is eligible for grant in cycle t+1. Minimum latency from eject to out_valid is 2 cycles.
- Ordering: per-lane FIFO order is preserved. There is no ordering guarantee across lanes.
- A lane that is non-empty is granted within NUM_LANES*(LOCAL_MAX_STREAK+1) load cycles.
- Reset mid-operation discards all buffered and output flits; overflow_sticky clears.

Test Plan:
- Single lane: lane 2 ejects one flit, op=4'b1100, out_ready=1 -> out_valid high 2 cycles later with identical flit; all other lanes idle.
- Filter: lane 0 ejects op=4'b0101 and op=4'b1011 -> nothing output, FIFO count stays 0.
- Round-robin: lanes 0, 3 and 5 each hold 2 flits, out_ready=1 -> grant order 0,3,5,0,3,5.
- Local priority bound: local_valid continuous with LOCAL_MAX_STREAK=4, lane 1 holding 1 flit -> 4 local outputs, then the lane 1 flit, then local resumes.
- Backpressure/overflow: out_ready=0, lane 4 receives 17 reduce flits -> lane_full[4]=1 after 16, overflow_sticky[4]=1. out_flit holds. Releasing out_ready drains 16 flits in order.
- Full push+pop: lane 4 full, with a simultaneous pop and push -> count stays 16, sticky not set. Assert rst low mid-stream -> out_valid=0 immediately (asynchronous), all counts 0.

Source files
------------

// File: rtl/reduce_ingress_arbiter.sv
// Reduce ingress: per-lane FWFT FIFOs plus local injection, round-robin arbitrated into one registered output.
// Eject-to-output latency is 2 cycles; out_ready low stalls the output and lanes, and a full lane drops flits (sticky flag).
module reduce_ingress_arbiter #(
    parameter int NUM_LANES        = 6,
    parameter int FLIT_W           = 85,
    parameter int VALID_POS        = 81,
    parameter int OP_POS           = 32,
    parameter int LANE_DEPTH       = 16,
    parameter int LG_DEPTH         = 4,
    parameter int LOCAL_MAX_STREAK = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANES*FLIT_W-1:0] eject_flit,
    input  logic [NUM_LANES-1:0]        eject_valid,
    output logic [NUM_LANES-1:0]        lane_full,
    output logic [NUM_LANES-1:0]        overflow_sticky,
    input  logic [FLIT_W-1:0]           local_flit,
    output logic                        local_ready,
    output logic [FLIT_W-1:0]           out_flit,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SW = $clog2(LOCAL_MAX_STREAK + 1);
    localparam logic [LG_DEPTH:0] FULL_CNT   = (LG_DEPTH + 1)'(LANE_DEPTH);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(LOCAL_MAX_STREAK);
    localparam logic [LW-1:0]     LAST_LANE  = LW'(NUM_LANES - 1);

    logic [NUM_LANES-1:0] push_req;
    logic [NUM_LANES-1:0] push_ok;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] non_empty;
    logic [FLIT_W-1:0]    lane_head [NUM_LANES];

    logic          load;
    logic          any_lane;
    logic          local_req;
    logic          local_win;
    logic          lane_win;
    logic [LW-1:0] grant_idx;

    logic [LW-1:0]     rr_q,        rr_d;
    logic [SW-1:0]     streak_q,    streak_d;
    logic              out_valid_q, out_valid_d;
    logic [FLIT_W-1:0] out_flit_q,  out_flit_d;

    // First non-empty lane at or after start, wrapping past the last lane.
    function automatic logic [LW-1:0] pick_lane(input logic [NUM_LANES-1:0] ne,
                                                 input logic [LW-1:0]        start);
        logic [LW-1:0] sel;
        logic [LW-1:0] cand;
        logic          found;
        int            idx;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            cand = LW'(idx);
            if (!found && ne[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return sel;
    endfunction

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [FLIT_W-1:0]   in_flit;
        logic [FLIT_W-1:0]   mem_q [LANE_DEPTH];
        logic [LG_DEPTH-1:0] wr_ptr_q;
        logic [LG_DEPTH-1:0] rd_ptr_q;
        logic [LG_DEPTH:0]   cnt_q;
        logic                sticky_q;
        logic                full;

        assign in_flit     = eject_flit[g*FLIT_W +: FLIT_W];
        assign push_req[g] = eject_valid[g] && in_flit[VALID_POS]
                             && (in_flit[OP_POS+3:OP_POS+2] == 2'b11);
        assign full        = (cnt_q == FULL_CNT);
        assign non_empty[g] = (cnt_q != '0);
        assign pop[g]      = lane_win && (grant_idx == LW'(g));
        // A full lane still accepts a flit when its head leaves in the same cycle.
        assign push_ok[g]  = push_req[g] && (!full || pop[g]);
        assign lane_head[g] = mem_q[rd_ptr_q];
        assign lane_full[g] = full;
        assign overflow_sticky[g] = sticky_q;

        always_ff @(posedge clk) begin
            if (push_ok[g]) mem_q[wr_ptr_q] <= in_flit;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end else begin
                if (push_ok[g]) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop[g])     rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push_ok[g] && !pop[g])      cnt_q <= cnt_q + 1'b1;
                else if (!push_ok[g] && pop[g]) cnt_q <= cnt_q - 1'b1;
                if (push_req[g] && !push_ok[g]) sticky_q <= 1'b1;
            end
        end
    end

    assign load      = !out_valid_q || out_ready;
    assign any_lane  = |non_empty;
    assign local_req = local_flit[VALID_POS];
    assign local_win = load && local_req && (!any_lane || (streak_q < STREAK_MAX));
    assign lane_win  = load && any_lane && !local_win;
    assign grant_idx = pick_lane(non_empty, rr_q);
    assign local_ready = rst && local_win;

    always_comb begin
        rr_d        = rr_q;
        streak_d    = streak_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        if (load) begin
            if (local_win) begin
                out_valid_d = 1'b1;
                out_flit_d  = local_flit;
                // Streak only counts local grants that made a pending lane wait.
                if (!any_lane)                 streak_d = '0;
                else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
            end else if (lane_win) begin
                out_valid_d = 1'b1;
                out_flit_d  = lane_head[grant_idx];
                rr_d        = (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
                streak_d    = '0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q        <= '0;
            streak_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            rr_q        <= rr_d;
            streak_q    <= streak_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;

endmodule

// File: tb/tb_reduce_ingress_arbiter.sv
// Directed and randomized bench for reduce_ingress_arbiter against a queue-based reference model.
module tb_reduce_ingress_arbiter;
    localparam int N  = 6;
    localparam int W  = 85;
    localparam int VP = 81;
    localparam int OP = 32;
    localparam int D  = 16;
    localparam int MS = 4;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] eject_flit;
    logic [N-1:0]   eject_valid;
    logic [N-1:0]   lane_full;
    logic [N-1:0]   overflow_sticky;
    logic [W-1:0]   local_flit;
    logic           local_ready;
    logic [W-1:0]   out_flit;
    logic           out_valid;
    logic           out_ready;

    reduce_ingress_arbiter #(
        .NUM_LANES(N), .FLIT_W(W), .VALID_POS(VP), .OP_POS(OP),
        .LANE_DEPTH(D), .LG_DEPTH(4), .LOCAL_MAX_STREAK(MS)
    ) dut (
        .clk(clk), .rst(rst),
        .eject_flit(eject_flit), .eject_valid(eject_valid),
        .lane_full(lane_full), .overflow_sticky(overflow_sticky),
        .local_flit(local_flit), .local_ready(local_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per lane plus the output register contents.
    logic [W-1:0] mq [N][$];
    logic         m_vld;
    logic [W-1:0] m_flit;
    int           m_rr;
    int           m_streak;
    logic [N-1:0] m_sticky;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkflit(input logic [3:0] op, input logic v);
        logic [W-1:0] f;
        f = W'({$urandom, $urandom, $urandom});
        f[VP] = v;
        f[OP +: 4] = op;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_vld    = 1'b0;
        m_flit   = '0;
        m_rr     = 0;
        m_streak = 0;
        m_sticky = '0;
    endtask

    task automatic idle_inputs();
        eject_valid = '0;
        eject_flit  = '0;
        local_flit  = '0;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] f);
        eject_flit[i*W +: W] = f;
        eject_valid[i[2:0]]  = 1'b1;
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_out_flit", out_flit, '0);
        chk("rst_lane_full", W'(lane_full), '0);
        chk("rst_sticky", W'(overflow_sticky), '0);
        chk("rst_local_ready", W'(local_ready), W'(1'b0));
    endtask

    // Compare at the falling edge, then advance the model by one rising edge.
    task automatic cycle();
        logic         any;
        logic         load;
        logic         lwin;
        logic [N-1:0] ef;
        logic [W-1:0] f;
        int           g;
        @(negedge clk);
        any = 1'b0;
        ef  = '0;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0) any = 1'b1;
            ef[i[2:0]] = (mq[i].size() == D);
        end
        load = !m_vld || out_ready;
        lwin = load && local_flit[VP] && (!any || m_streak < MS);
        chk("out_valid", W'(out_valid), W'(m_vld));
        chk("out_flit", out_flit, m_flit);
        chk("lane_full", W'(lane_full), W'(ef));
        chk("overflow_sticky", W'(overflow_sticky), W'(m_sticky));
        chk("local_ready", W'(local_ready), W'(lwin));
        if (load) begin
            if (lwin) begin
                m_flit   = local_flit;
                m_vld    = 1'b1;
                m_streak = !any ? 0 : ((m_streak < MS) ? m_streak + 1 : MS);
            end else if (any) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
                m_flit   = mq[g].pop_front();
                m_rr     = (g + 1) % N;
                m_streak = 0;
                m_vld    = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end
        // Pops above happen first, so a full lane that was just granted has room.
        for (int i = 0; i < N; i++) begin
            f = eject_flit[i*W +: W];
            if (eject_valid[i[2:0]] && f[VP] && f[OP+3:OP+2] == 2'b11) begin
                if (mq[i].size() < D) mq[i].push_back(f);
                else m_sticky[i[2:0]] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        local_flit = mkflit(4'hC, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
    endtask

    task automatic stall_output();
        out_ready  = 1'b0;
        idle_inputs();
        local_flit = mkflit(4'h0, 1'b1);
        cycle();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        local_flit = mkflit(4'hC, 1'b1);
        model_reset();
        #1 rst = 1'b0;
        #2 check_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();

        // Single flit on lane 2
        out_ready = 1'b1;
        set_lane(2, mkflit(4'hC, 1'b1));
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // Non-reduce opcodes are ignored
        set_lane(0, mkflit(4'h5, 1'b1));
        cycle();
        idle_inputs();
        set_lane(0, mkflit(4'hB, 1'b1));
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // Round-robin across lanes 0, 3, 5
        out_ready = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            idle_inputs();
            set_lane(0, mkflit(4'hC, 1'b1));
            set_lane(3, mkflit(4'hD, 1'b1));
            set_lane(5, mkflit(4'hE, 1'b1));
            cycle();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (10) cycle();

        // Local streak bound against pending lane 1
        set_lane(1, mkflit(4'hF, 1'b1));
        local_flit = mkflit(4'h3, 1'b1);
        cycle();
        eject_valid = '0;
        repeat (9) begin
            local_flit = mkflit(4'h3, 1'b1);
            cycle();
        end
        idle_inputs();
        repeat (2) cycle();

        // Backpressure and overflow on lane 4
        stall_output();
        repeat (17) begin
            eject_valid = '0;
            set_lane(4, mkflit(4'hD, 1'b1));
            cycle();
        end
        idle_inputs();
        cycle();
        chk("lane4_full_after_17", W'(lane_full[4]), W'(1'b1));
        chk("lane4_sticky_after_17", W'(overflow_sticky[4]), W'(1'b1));
        out_ready = 1'b1;
        repeat (20) cycle();

        // Asynchronous reset with data in flight
        stall_output();
        set_lane(1, mkflit(4'hC, 1'b1));
        set_lane(4, mkflit(4'hC, 1'b1));
        cycle();
        mid_reset();

        // Full lane with simultaneous pop and push
        stall_output();
        repeat (16) begin
            eject_valid = '0;
            set_lane(4, mkflit(4'hC, 1'b1));
            cycle();
        end
        idle_inputs();
        cycle();
        chk("lane4_full_16", W'(lane_full[4]), W'(1'b1));
        chk("lane4_no_sticky_16", W'(overflow_sticky[4]), W'(1'b0));
        out_ready = 1'b1;
        set_lane(4, mkflit(4'hC, 1'b1));
        cycle();
        idle_inputs();
        out_ready = 1'b0;
        cycle();
        chk("lane4_full_pushpop", W'(lane_full[4]), W'(1'b1));
        chk("lane4_no_sticky_pushpop", W'(overflow_sticky[4]), W'(1'b0));
        out_ready = 1'b1;
        repeat (20) cycle();

        // Randomized traffic
        repeat (1500) begin
            eject_valid = '0;
            eject_flit  = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 35)
                    set_lane(i, mkflit(($urandom_range(0, 99) < 70) ?
                                       (4'hC | 4'($urandom_range(0, 3))) :
                                       4'($urandom_range(0, 15)),
                                       $urandom_range(0, 9) != 0));
            end
            local_flit = mkflit(4'($urandom_range(0, 15)), $urandom_range(0, 99) < 30);
            out_ready  = $urandom_range(0, 99) < 65;
            cycle();
        end
        mid_reset();
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
